// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle shared by the requesters and the FIFO:
// request words in, one-hot acks and FIFO write port out.
interface fifo_wr_arbiter_if #(
  parameter int DW = 8,
  parameter int NR = 4
);
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    ack;
  logic             full;
  logic             wr_en;
  logic [DW-1:0]    data_in;

  modport master (
    output req, req_data, req_last, full,
    input  ack, wr_en, data_in
  );

  modport slave (
    input  req, req_data, req_last, full,
    output ack, wr_en, data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side.
// Grants last one packet or up to MAX_BURST words; never writes when full.
module fifo_wr_arbiter #(
  parameter int Data_Width = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  fifo_wr_arbiter_if.slave    bus,
  output logic [GW-1:0]       grant_id,
  output logic                busy,
  output logic [15:0]         wr_count
);

  localparam logic [7:0] BLAST = 8'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gid_q, gid_d;
  logic [GW-1:0]   last_q, last_d;
  logic [7:0]      burst_q, burst_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [GW-1:0]   pick;
  logic            found;
  int              rr_idx;
  logic            accept;
  logic [Data_Width-1:0] words [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = bus.req_data[i*Data_Width +: Data_Width];
    end
  end

  // first requester strictly after last_q, wrapping
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = int'(last_q) + i;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!found && bus.req[GW'(rr_idx)]) begin
        found = 1'b1;
        pick  = GW'(rr_idx);
      end
    end
  end

  assign accept = (state_q == GRANT) & bus.req[gid_q] & ~bus.full;

  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    last_d      = last_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    bus.wr_en   = 1'b0;
    bus.ack     = '0;
    bus.data_in = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = pick;
          last_d  = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        bus.wr_en = accept;
        if (accept) begin
          bus.ack[gid_q] = 1'b1;
          bus.data_in    = words[gid_q];
          burst_d        = burst_q + 8'd1;
          cnt_d          = cnt_q + 16'd1;
        end
        if (!bus.req[gid_q] ||
            (accept && (bus.req_last[gid_q] || burst_q == BLAST))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = gid_q;
  assign busy     = (state_q == GRANT);
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for round robin,
// hand-written sequences for burst cap, full stall, abandon and wrap.
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        wr_rst;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_count;

  int ncmp = 0;
  int nerr = 0;
  int exp_cnt;

  fifo_wr_arbiter_if #(.DW(8), .NR(4)) bus ();

  fifo_wr_arbiter #(
    .Data_Width(8),
    .NUM_REQ(4),
    .MAX_BURST(16)
  ) dut (
    .wr_clk  (wr_clk),
    .wr_rst  (wr_rst),
    .bus     (bus),
    .grant_id(grant_id),
    .busy    (busy),
    .wr_count(wr_count)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic       wr_en;
    logic [3:0] ack;
    logic       busy;
    logic [1:0] gid;
    logic [7:0] data;
  } vec_t;

  vec_t tbl [15];

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] g,
                     input logic [31:0] e);
    ncmp++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", n, g, e);
    end
  endtask

  task automatic chk_wr(input string n, input logic [3:0] a,
                        input logic [7:0] d);
    chk({n, "_wr_en"}, bus.wr_en, 1'b1);
    chk({n, "_ack"}, bus.ack, a);
    chk({n, "_data"}, bus.data_in, d);
  endtask

  task automatic chk_stall(input string n);
    chk({n, "_wr_en"}, bus.wr_en, 1'b0);
    chk({n, "_ack"}, bus.ack, 4'h0);
    chk({n, "_data"}, bus.data_in, 8'h00);
  endtask

  initial begin
    int n;
    int cyc;
    int npre;

    tbl[0]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
    tbl[2]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
    tbl[3]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
    tbl[4]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 8'h00};
    tbl[5]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
    tbl[6]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2, 8'h00};
    tbl[7]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
    tbl[8]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 8'h00};
    tbl[9]  = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
    tbl[10] = '{4'h0, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
    tbl[11] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
    tbl[12] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd1, 8'h00};
    tbl[13] = '{4'hF, 4'hF, 1'b0, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
    tbl[14] = '{4'h0, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 8'h00};

    wr_rst       = 1'b1;
    bus.req      = 4'hF;
    bus.req_last = 4'h0;
    bus.full     = 1'b0;
    bus.req_data = '0;

    // reset held for three edges with every requester asserting
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge wr_clk);
      chk("rst_wr_en", bus.wr_en, 1'b0);
      chk("rst_ack", bus.ack, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cnt", wr_count, 16'd0);
      chk("rst_data", bus.data_in, 8'h00);
      tick();
    end
    wr_rst       = 1'b0;
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    for (int i = 0; i < 15; i++) begin
      bus.req      = tbl[i].req;
      bus.req_last = tbl[i].last;
      bus.full     = tbl[i].full;
      @(negedge wr_clk);
      chk($sformatf("rr%0d_wr_en", i), bus.wr_en, tbl[i].wr_en);
      chk($sformatf("rr%0d_ack", i), bus.ack, tbl[i].ack);
      chk($sformatf("rr%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("rr%0d_gid", i), grant_id, tbl[i].gid);
      chk($sformatf("rr%0d_data", i), bus.data_in, tbl[i].data);
      tick();
    end
    exp_cnt = 6;
    @(negedge wr_clk);
    chk("rr_count", wr_count, 16'(exp_cnt));
    tick();

    // burst cap: requester 2 streams, requester 1 waits
    bus.req      = 4'b0100;
    bus.req_last = 4'b0000;
    bus.req_data[2*8 +: 8] = 8'h20;
    @(negedge wr_clk);
    chk("cap_idle_busy", busy, 1'b0);
    tick();
    bus.req      = 4'b0110;
    bus.req_last = 4'b0010;
    bus.req_data[1*8 +: 8] = 8'h11;
    for (int k = 0; k < 16; k++) begin
      @(negedge wr_clk);
      chk_wr($sformatf("cap_w%0d", k), 4'b0100, 8'(8'h20 + k));
      tick();
      bus.req_data[2*8 +: 8] = 8'(8'h21 + k);
    end
    @(negedge wr_clk);
    chk("cap_rel_busy", busy, 1'b0);
    chk("cap_rel_wr_en", bus.wr_en, 1'b0);
    chk("cap_count", wr_count, 16'(exp_cnt + 16));
    tick();
    @(negedge wr_clk);
    chk("cap_next_gid", grant_id, 2'd1);
    chk_wr("cap_r1", 4'b0010, 8'h11);
    tick();
    bus.req = 4'b0000;
    exp_cnt = exp_cnt + 17;
    @(negedge wr_clk);
    chk("cap_end_count", wr_count, 16'(exp_cnt));
    tick();

    // full stall after word 3 of requester 3's burst
    bus.req      = 4'b1000;
    bus.req_last = 4'b0000;
    bus.req_data[3*8 +: 8] = 8'h30;
    @(negedge wr_clk);
    chk("stall_idle_busy", busy, 1'b0);
    tick();
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        for (int s = 0; s < 5; s++) begin
          bus.full = 1'b1;
          @(negedge wr_clk);
          chk_stall($sformatf("stall_s%0d", s));
          chk($sformatf("stall_s%0d_busy", s), busy, 1'b1);
          tick();
        end
        bus.full = 1'b0;
      end
      @(negedge wr_clk);
      chk_wr($sformatf("stall_w%0d", k), 4'b1000, 8'(8'h30 + k));
      tick();
      bus.req_data[3*8 +: 8] = 8'(8'h31 + k);
    end
    @(negedge wr_clk);
    chk("stall_rel_busy", busy, 1'b0);
    chk("stall_count", wr_count, 16'(exp_cnt + 16));
    exp_cnt = exp_cnt + 16;
    bus.req = 4'b0000;
    tick();

    // requester 1 abandons after two words
    bus.req      = 4'b0010;
    bus.req_last = 4'b0000;
    bus.req_data[1*8 +: 8] = 8'h40;
    @(negedge wr_clk);
    chk("ab_idle_busy", busy, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge wr_clk);
      chk_wr($sformatf("ab_w%0d", k), 4'b0010, 8'(8'h40 + k));
      chk($sformatf("ab_w%0d_gid", k), grant_id, 2'd1);
      tick();
      bus.req_data[1*8 +: 8] = 8'(8'h41 + k);
    end
    bus.req = 4'b0000;
    @(negedge wr_clk);
    chk_stall("ab_drop");
    tick();
    @(negedge wr_clk);
    chk("ab_rel_busy", busy, 1'b0);
    chk("ab_rel_wr_en", bus.wr_en, 1'b0);
    exp_cnt = exp_cnt + 2;
    chk("ab_count", wr_count, 16'(exp_cnt));
    tick();

    // preload wr_count to 65534 through requester 0, then wrap
    npre = 65534 - exp_cnt;
    n    = 0;
    cyc  = 0;
    bus.req      = 4'b0001;
    bus.req_last = 4'b0000;
    bus.req_data[0*8 +: 8] = 8'h55;
    while (n < npre && cyc < 80000) begin
      @(negedge wr_clk);
      if (bus.ack[0] && bus.wr_en) n++;
      tick();
      cyc++;
    end
    bus.req = 4'b0000;
    chk("pre_bound", n, npre);
    tick();
    @(negedge wr_clk);
    chk("pre_busy", busy, 1'b0);
    chk("pre_count", wr_count, 16'd65534);
    tick();
    bus.req = 4'b0001;
    tick();
    @(negedge wr_clk);
    chk("wrap_w0_cnt", wr_count, 16'd65534);
    chk_wr("wrap_w0", 4'b0001, 8'h55);
    tick();
    @(negedge wr_clk);
    chk("wrap_w1_cnt", wr_count, 16'd65535);
    chk_wr("wrap_w1", 4'b0001, 8'h55);
    tick();
    @(negedge wr_clk);
    chk("wrap_w2_cnt", wr_count, 16'd0);
    chk_wr("wrap_w2", 4'b0001, 8'h55);
    tick();
    bus.req = 4'b0000;
    @(negedge wr_clk);
    chk("wrap_end_cnt", wr_count, 16'd1);
    chk_stall("wrap_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
